seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed driver for a multi-digit seven-segment display. It latches a packed hex value on a load strobe and decodes each nibble to segments, covering all 16 codes rather than a single segment. It scans one digit at a time with a programmable dwell, an anti-ghosting blank interval and leading-zero suppression. It sits between register-file/debug logic and the board's shared-segment display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8); digit 0 is least significant.
REFRESH_DIV, 50000, clock cycles each digit slot lasts (>=2).
BLANK_CYC, 500, cycles at the start of each slot with all anodes off (0 <= BLANK_CYC < REFRESH_DIV).
ACTIVE_LOW, 1, when 1, seg, dp and an are driven active-low; when 0, active-high.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load  in  1  capture strobe for value/dp_in/blank_mask/lz_en
value  in  4*NUM_DIGITS  packed hex digits; digit i = value[4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point request per digit
blank_mask  in  NUM_DIGITS  1 = force digit i dark
lz_en  in  1  leading-zero suppression enable
seg  out  7  segments, seg[0]=a .. seg[6]=g
dp  out  1  decimal point
an  out  NUM_DIGITS  digit enables, one-hot when active
frame_tick  out  1  one-cycle pulse per completed scan frame

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Reset: cnt=0, idx=0, all shadow registers=0, frame_tick=0. seg, dp and an all at the inactive level: all 1s if ACTIVE_LOW, else all 0s.
- Reset mid-scan or mid-load behaves identically. Reset dominates load in the same cycle.
- Slot counter cnt, width $clog2(REFRESH_DIV):
  - Increments every cycle.
  - At REFRESH_DIV-1 it wraps to 0 and idx advances modulo NUM_DIGITS.
  - Frame length is NUM_DIGITS*REFRESH_DIV cycles.
- Shadow capture: load=1 at edge k copies value, dp_in, blank_mask and lz_en. Edges without load hold the shadow. A held-high load re-captures every cycle.
- Outputs are registered. At each non-reset edge, seg/dp/an are computed from the pre-edge cnt, idx and shadow registers.
  - Load at edge k is therefore first visible on the outputs after edge k+1, even when k coincides with a slot change.
- Digit dark condition, evaluated for digit idx. The digit is dark when any of the following holds:
  - cnt < BLANK_CYC;
  - blank_mask[idx] = 1;
  - lz_en=1, idx>0, and nibbles idx..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed by leading-zero suppression.
- When dark, an, seg and dp are all inactive.
- Otherwise:
  - an is one-hot at bit idx.
  - seg is the hex pattern of nibble idx.
  - dp = dp_in[idx].
  - Polarity is applied per ACTIVE_LOW.
- Hex table, active-high, as gfedcba:
  0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- frame_tick is registered. It is 1 for exactly the cycle after the edge where idx wraps from NUM_DIGITS-1 to 0, and 0 otherwise.
- NUM_DIGITS=1: idx stays 0; frame_tick pulses once every REFRESH_DIV cycles.

Decomposition:
- seg7_pkg holds:
  - the 16-entry hex segment table as a localparam array;
  - a function hex2seg(logic [3:0]) returning logic [6:0], active-high;
  - segment index constants SEG_A..SEG_G.
- One sub-module, seg7_hex_dec: purely combinational nibble to 7-bit active-high pattern, built on hex2seg.
- Polarity, blanking and scan logic live in seg7_scan_driver.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1, ACTIVE_LOW=1 unless stated.
1. Reset: hold rst 3 cycles -> seg=7'h7F, dp=1, an=4'hF, frame_tick=0 every cycle. After release: digit 0 dark for 1 cycle, then an=4'hE, seg=~7'h3F=7'h40 for 3 cycles.
2. Load value=16'h12AF, dp_in=0, lz_en=0 -> outputs:
   - slot 0: an=E, seg=7'h0E;
   - slot 1: an=D, seg=7'h08;
   - slot 2: an=B, seg=7'h24;
   - slot 3: an=7, seg=7'h79.
   Each slot has 1 blank cycle then 3 lit cycles. frame_tick pulses once per 16 cycles.
3. Leading-zero suppression: load value=16'h0050, lz_en=1 ->
   - digits 3 and 2 dark for whole slots;
   - digit 1 shows 5 (seg=7'h12);
   - digit 0 shows 0 (seg=7'h40).
   Then load value=16'h0000 -> only digit 0 lit.
4. blank_mask=4'b0010 with dp_in=4'b0001 -> digit 1 fully dark; dp=0 only during digit 0's lit cycles.
5. Load asserted on the same edge cnt wraps to a new slot -> the first lit cycle of the new slot already shows the new value. Assert rst mid-slot -> next cycle all outputs inactive and cnt=idx=0.
6. ACTIVE_LOW=0, NUM_DIGITS=1, value=4'h8 -> an=1, seg=7'h7F during lit cycles; frame_tick every 4 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver.
// The hex table and hex2seg() are active-high, bit order gfedcba.
package seg7_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Lower-case b and d keep 8/B and 0/D distinguishable.
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return HEX_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Nibble to active-high seven-segment pattern (gfedcba).
// Purely combinational, zero latency, no flow control.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex2seg(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver with blanking and leading-zero suppression.
// Outputs registered one cycle after the scan state they reflect; free-running, no backpressure.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic             INV       = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dpin_q, dpin_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic                    lz_q, lz_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic [3:0]            nib_sel;
  logic                  dp_sel, blank_sel, lz_sel, upper_zero, dark;
  logic [NUM_DIGITS-1:0] an_hot;
  logic [6:0]            seg_hex;

  seg7_hex_dec u_dec (
    .nib_i (nib_sel),
    .seg_o (seg_hex)
  );

  // Walk from the top digit down so upper_zero covers nibbles i..NUM_DIGITS-1.
  always_comb begin
    nib_sel    = 4'h0;
    dp_sel     = 1'b0;
    blank_sel  = 1'b0;
    lz_sel     = 1'b0;
    an_hot     = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (value_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib_sel   = value_q[4*i +: 4];
        dp_sel    = dpin_q[i];
        blank_sel = blank_q[i];
        lz_sel    = upper_zero && (i != 0);
        an_hot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    dark    = (cnt_q < CNT_BLANK) | blank_sel | (lz_q & lz_sel);
    seg_d   = (dark ? 7'h00 : seg_hex) ^ {7{INV}};
    dp_d    = (~dark & dp_sel) ^ INV;
    an_d    = (dark ? '0 : an_hot) ^ {NUM_DIGITS{INV}};
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      frame_d = (idx_q == IDX_LAST);
    end
    value_d = load ? value      : value_q;
    dpin_d  = load ? dp_in      : dpin_q;
    blank_d = load ? blank_mask : blank_q;
    lz_d    = load ? lz_en      : lz_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      value_q <= '0;
      dpin_q  <= '0;
      blank_q <= '0;
      lz_q    <= 1'b0;
      seg_q   <= {7{INV}};
      dp_q    <= INV;
      an_q    <= {NUM_DIGITS{INV}};
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      dpin_q  <= dpin_d;
      blank_q <= blank_d;
      lz_q    <= lz_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit active-low instance and a 1-digit active-high instance
// checked every cycle against a time-based reference model.
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  logic        load1 = 1'b0;
  logic [3:0]  value1 = '0;
  logic        dp1_in = 1'b0;
  logic        bm1 = 1'b0;
  logic        lz1 = 1'b0;
  logic [6:0]  seg1;
  logic        dp1;
  logic        an1;
  logic        ft1;

  int checks = 0;
  int errors = 0;

  logic [6:0] ref_hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: cycles since reset plus the captured shadow of each instance.
  int          m_t = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0, m_bm = '0;
  logic        m_lz = 1'b0;
  int          m1_t = 0;
  logic [3:0]  m1_val = '0;
  logic        m1_dp = 1'b0, m1_bm = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYC(B), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_en(lz_en),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(R), .BLANK_CYC(B), .ACTIVE_LOW(0)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .value(value1), .dp_in(dp1_in),
    .blank_mask(bm1), .lz_en(lz1),
    .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %h expected %h", tag, m_t, obs, exp);
    end
  endtask

  task automatic tick();
    logic [6:0]  e_seg, e1_seg;
    logic        e_dp, e_ft, e1_dp, e1_an, e1_ft, dark, dark1;
    logic [3:0]  e_an;
    logic [15:0] hi;
    int          d, pos, pos1;
    if (rst) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = 1'b0;
      e1_seg = 7'h00; e1_dp = 1'b0; e1_an = 1'b0; e1_ft = 1'b0;
    end else begin
      pos  = m_t % R;
      d    = (m_t / R) % N;
      hi   = m_val >> (4 * d);
      dark = (pos < B) || m_bm[d] || (m_lz && d > 0 && hi == 16'h0);
      e_seg = dark ? 7'h7F : ~ref_hex[hi[3:0]];
      e_dp  = dark ? 1'b1 : ~m_dp[d];
      e_an  = dark ? 4'hF : ~(4'(1) << d);
      e_ft  = (pos == R - 1) && (d == N - 1);
      pos1  = m1_t % R;
      dark1 = (pos1 < B) || m1_bm;
      e1_seg = dark1 ? 7'h00 : ref_hex[m1_val];
      e1_dp  = dark1 ? 1'b0 : m1_dp;
      e1_an  = ~dark1;
      e1_ft  = (pos1 == R - 1);
    end
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_val = '0; m_dp = '0; m_bm = '0; m_lz = 1'b0;
      m1_t = 0; m1_val = '0; m1_dp = 1'b0; m1_bm = 1'b0;
    end else begin
      m_t++;
      m1_t++;
      if (load) begin
        m_val = value; m_dp = dp_in; m_bm = blank_mask; m_lz = lz_en;
      end
      if (load1) begin
        m1_val = value1; m1_dp = dp1_in; m1_bm = bm1;
      end
    end
    #1;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("an", 32'(an), 32'(e_an));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
    chk("seg1", 32'(seg1), 32'(e1_seg));
    chk("dp1", 32'(dp1), 32'(e1_dp));
    chk("an1", 32'(an1), 32'(e1_an));
    chk("frame_tick1", 32'(ft1), 32'(e1_ft));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset held with a load pending: reset must win.
    rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
    run(3);
    load = 1'b0; rst = 1'b0;
    run(8);

    // Plain hex display, plus the single-digit instance showing 8.
    value = 16'h12AF; dp_in = 4'h0; blank_mask = 4'h0; lz_en = 1'b0; load = 1'b1;
    value1 = 4'h8; dp1_in = 1'b0; bm1 = 1'b0; load1 = 1'b1;
    tick();
    load = 1'b0; load1 = 1'b0;
    run(34);

    // Leading-zero suppression, then an all-zero value.
    value = 16'h0050; lz_en = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    run(32);
    value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    run(32);

    // Forced-dark digit 1 and decimal point on digit 0.
    value = 16'h4321; lz_en = 1'b0; blank_mask = 4'b0010; dp_in = 4'b0001; load = 1'b1;
    tick();
    load = 1'b0;
    run(32);

    // Load coinciding with a slot change.
    while (m_t % R != R - 1) tick();
    value = 16'hBEEF; blank_mask = 4'h0; dp_in = 4'b1010; load = 1'b1;
    tick();
    load = 1'b0;
    run(6);

    // Reset in the middle of a slot.
    while (m_t % R != 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(20);

    // Load held high with a changing value.
    load = 1'b1; load1 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      value = 16'($urandom); value1 = 4'($urandom); dp_in = 4'($urandom);
      tick();
    end
    load = 1'b0; load1 = 1'b0;

    // Randomised traffic with sporadic loads and resets.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(63) == 0);
      load       = ($urandom_range(7) == 0);
      value      = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(255));
      dp_in      = 4'($urandom);
      blank_mask = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      lz_en      = 1'($urandom);
      load1      = ($urandom_range(5) == 0);
      value1     = 4'($urandom);
      dp1_in     = 1'($urandom);
      bm1        = ($urandom_range(4) == 0);
      lz1        = 1'($urandom);
      tick();
    end
    rst = 1'b0; load = 1'b0; load1 = 1'b0;
    run(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
